rst_req_gen: RTL and testbench
==============================

// Module: rst_req_gen
// PURPOSE
//  Source side of the reset-crossing protocol: drives an active-low reset request into a destination
//  domain's reset synchronizer and tracks that domain's reset status through an acknowledge line.
//  Stretches power-on and software resets to a guaranteed minimum width, then waits for the
//  destination to acknowledge entry into and exit from reset. Flags a sticky error on timeout.
//  Sits in the system-control domain, one instance per controlled clock domain.
// PARAMETERS
//  HOLD_CYCLES     8   minimum cycles RST_N_OUT is held low per request (>=1)
//  TIMEOUT_CYCLES  64  max cycles spent waiting in WAIT_ACK or WAIT_REL before a forced advance
//  CNT_WIDTH       8   counter width; must hold max(HOLD_CYCLES,TIMEOUT_CYCLES)-1
//  SYNC_STAGES     2   flops in the ACK synchronizer chain (>=2)
// PORTS
//  CLK         in   1  source-domain clock
//  RST         in   1  asynchronous, active-high reset
//  SW_RST_REQ  in   1  synchronous software reset request, level sampled in IDLE only
//  RST_ACK     in   1  async from destination: 1 = destination's synchronized reset is asserted
//  RST_N_OUT   out  1  registered active-low reset request to destination synchronizer
//  BUSY        out  1  1 whenever state != IDLE
//  TIMEOUT     out  1  sticky: an acknowledge wait expired
// BEHAVIOUR
//  - During RST: state=HOLD, cnt=0, RST_N_OUT=0, BUSY=1, TIMEOUT=0, ack sync chain all 0.
//    Power-on reset therefore receives the full stretch and handshake after RST falls.
//  - ack_s = RST_ACK after SYNC_STAGES flops; the FSM uses only ack_s.
//  - All outputs are registered and glitch-free. RST_N_OUT changes only on the CLK edge that performs
//    the state transition.
//  - FSM:
//    IDLE:     RST_N_OUT=1, BUSY=0. SW_RST_REQ=1 -> HOLD, cnt=0, TIMEOUT cleared.
//              Latency: request sampled at edge N gives RST_N_OUT=0 after edge N.
//    HOLD:     RST_N_OUT=0. cnt++. At cnt==HOLD_CYCLES-1 -> WAIT_ACK, cnt=0.
//              The low time is exactly HOLD_CYCLES cycles when ack_s is already 1.
//    WAIT_ACK: RST_N_OUT=0. ack_s=1 -> WAIT_REL, cnt=0, RST_N_OUT=1 from that edge.
//              At cnt==TIMEOUT_CYCLES-1 with ack_s=0 -> set TIMEOUT and go to WAIT_REL anyway.
//    WAIT_REL: RST_N_OUT=1. ack_s=0 -> IDLE.
//              At cnt==TIMEOUT_CYCLES-1 with ack_s=1 -> set TIMEOUT and go to IDLE.
//  - SW_RST_REQ outside IDLE is ignored; requests are not queued. A request held high across the
//    return to IDLE starts a new cycle on the first IDLE edge.
//  - Simultaneous events: ack_s and the timeout terminal count on the same edge -> the ack wins and
//    TIMEOUT stays unchanged.
//  - cnt saturates and never wraps. It is cleared on every state change.
//  - RST mid-operation returns the block to its reset values immediately (async). RST_N_OUT goes
//    low at once, with no glitch high.
//  - A spurious ack_s=1 in IDLE is ignored. The block does not self-trigger.
// STRUCTURE
//  - Shared package: FSM state encoding localparams (IDLE, HOLD, WAIT_ACK, WAIT_REL, 2-bit) and the
//    default HOLD/TIMEOUT values, also used by the system controller.
//  - One sub-module: bit_sync, a SYNC_STAGES-deep single-bit synchronizer with async active-high
//    reset and a reset value of 0, used for RST_ACK. The FSM, counter and output registers are in
//    the top module.
// TESTING
//  1 POR: RST=1 for 3 cycles, then 0; RST_ACK follows RST_N_OUT low after 4 cycles.
//    -> RST_N_OUT=0 for >=8 cycles, then 1 once ack_s=1. BUSY falls after ack_s returns to 0.
//    -> TIMEOUT=0 throughout.
//  2 SW reset: IDLE, SW_RST_REQ pulse for 1 cycle.
//    -> RST_N_OUT=0 on the next edge for exactly 8 cycles (ack already high by then).
//    -> Back to IDLE with RST_N_OUT=1.
//  3 Ack never asserts: RST_ACK held 0 after a request.
//    -> 8 HOLD cycles plus 64 WAIT_ACK cycles, then TIMEOUT=1, RST_N_OUT=1, then IDLE.
//    -> TIMEOUT clears on the next accepted request.
//  4 Ack stuck high: RST_ACK=1 permanently.
//    -> WAIT_REL times out after 64 cycles, TIMEOUT=1, IDLE.
//    -> A further SW_RST_REQ is accepted.
//  5 Request while BUSY: SW_RST_REQ pulses during HOLD and during WAIT_REL.
//    -> No extra low period on RST_N_OUT and no counter restart.
//  6 RST mid-WAIT_REL: assert RST asynchronously.
//    -> RST_N_OUT=0 and TIMEOUT=0 with no clock edge required.
//    -> A full sequence restarts after RST is released.

Source files
------------

// File: rtl/rst_req_gen_pkg.sv
// Shared definitions for the reset-request generator: FSM state encoding and
// the default stretch/timeout values also used by the system controller.
package rst_req_gen_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t HOLD     = 2'd1;
    localparam state_t WAIT_ACK = 2'd2;
    localparam state_t WAIT_REL = 2'd3;

    localparam int DEFAULT_HOLD_CYCLES    = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/rst_req_gen_bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset to 0.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignment lets every stage sample the previous stage's old value.
            sync_q <= {sync_q[STAGES-2:0], D};
        end
    end

    assign Q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_req_gen.sv
// Source side of the reset-crossing handshake: stretches a reset request,
// waits for the destination to acknowledge entry to and exit from reset, and
// flags a sticky timeout if either acknowledge wait expires.
module rst_req_gen
    import rst_req_gen_pkg::*;
#(
    parameter int HOLD_CYCLES    = DEFAULT_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW_RST_REQ,
    input  logic RST_ACK,
    output logic RST_N_OUT,
    output logic BUSY,
    output logic TIMEOUT
);

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic   [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   timeout_d;
    logic                   rst_n_d;
    logic                   busy_d;
    logic                   ack_s;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (RST_ACK),
        .Q   (ack_s)
    );

    // State, counter and registered outputs; reset holds the request asserted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            RST_N_OUT <= 1'b0;
            BUSY      <= 1'b1;
            TIMEOUT   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            RST_N_OUT <= rst_n_d;
            BUSY      <= busy_d;
            TIMEOUT   <= timeout_d;
        end
    end

    // Next state, sticky timeout flag and saturating counter.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d   = state_q;
        timeout_d = TIMEOUT;
        case (state_q)
            IDLE: begin
                if (SW_RST_REQ) begin
                    state_d   = HOLD;
                    timeout_d = 1'b0;
                end
            end
            HOLD: begin
                // With the ack already present, skip WAIT_ACK so the low time is exactly HOLD_CYCLES.
                if (cnt_q == HOLD_LAST) begin
                    state_d = ack_s ? WAIT_REL : WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s) begin
                    state_d = WAIT_REL;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = WAIT_REL;
                    timeout_d = 1'b1;
                end
            end
            WAIT_REL: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output values for the upcoming state, registered so outputs never glitch.
    always_comb begin
        rst_n_d = (state_d == IDLE) || (state_d == WAIT_REL);
        busy_d  = (state_d != IDLE);
    end

endmodule

// File: tb/tb_rst_req_gen.sv
// Directed bench for rst_req_gen with a behavioural destination domain whose
// acknowledge either follows the request with a 4-cycle delay or is forced.
module tb_rst_req_gen;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic SW_RST_REQ = 1'b0;
    logic RST_ACK;
    logic RST_N_OUT;
    logic BUSY;
    logic TIMEOUT;

    int checks = 0;
    int errors = 0;

    // 0: follow request with 4-cycle delay, 1: forced 0, 2: forced 1
    int       ack_mode = 0;
    logic [3:0] dst_sr = 4'b0000;

    always #5 CLK = ~CLK;

    rst_req_gen dut (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .RST_ACK    (RST_ACK),
        .RST_N_OUT  (RST_N_OUT),
        .BUSY       (BUSY),
        .TIMEOUT    (TIMEOUT)
    );

    // Destination reset status lags the request by four cycles.
    always @(posedge CLK) dst_sr <= {dst_sr[2:0], ~RST_N_OUT};

    always_comb begin
        case (ack_mode)
            1:       RST_ACK = 1'b0;
            2:       RST_ACK = 1'b1;
            default: RST_ACK = dst_sr[3];
        endcase
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Issue a one-cycle request; returns positioned just after the accepting edge.
    task automatic pulse_req();
        SW_RST_REQ = 1'b1;
        step();
        SW_RST_REQ = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (BUSY && n < budget) begin
            step();
            n++;
        end
        check(tag, (n < budget), 1'b1);
    endtask

    initial begin
        // ---- 1: power-on reset ----
        step(3);
        check("por_rst_n", RST_N_OUT, 1'b0);
        check("por_busy", BUSY, 1'b1);
        check("por_timeout", TIMEOUT, 1'b0);
        RST = 1'b0;
        step(7);
        check("por_low_e7", RST_N_OUT, 1'b0);
        check("por_timeout_hold", TIMEOUT, 1'b0);
        step();
        check("por_high_e8", RST_N_OUT, 1'b1);
        check("por_busy_e8", BUSY, 1'b1);
        step(6);
        check("por_busy_e14", BUSY, 1'b1);
        step();
        check("por_idle_e15", BUSY, 1'b0);
        check("por_rst_n_idle", RST_N_OUT, 1'b1);
        check("por_timeout_end", TIMEOUT, 1'b0);

        // ---- 2: software reset pulse ----
        step(3);
        pulse_req();
        check("sw_low_a0", RST_N_OUT, 1'b0);
        check("sw_busy_a0", BUSY, 1'b1);
        step(7);
        check("sw_low_a7", RST_N_OUT, 1'b0);
        step();
        check("sw_high_a8", RST_N_OUT, 1'b1);
        step(6);
        check("sw_busy_a14", BUSY, 1'b1);
        step();
        check("sw_idle_a15", BUSY, 1'b0);
        check("sw_rst_n_a15", RST_N_OUT, 1'b1);

        // ---- 5: requests while busy are ignored ----
        step(3);
        pulse_req();
        step(2);
        pulse_req();             // accepted edge would be A+3, in HOLD
        step(4);
        check("busy_req_low_a7", RST_N_OUT, 1'b0);
        step();
        check("busy_req_high_a8", RST_N_OUT, 1'b1);
        step();
        pulse_req();             // sampled at A+10, in WAIT_REL
        step(4);
        check("busy_req_busy_a14", BUSY, 1'b1);
        check("busy_req_rst_n_a14", RST_N_OUT, 1'b1);
        step();
        check("busy_req_idle_a15", BUSY, 1'b0);
        step(2);
        check("busy_req_no_requeue", BUSY, 1'b0);

        // ---- 3: acknowledge never asserts ----
        ack_mode = 1;
        step(2);
        pulse_req();
        step(71);
        check("noack_low_a71", RST_N_OUT, 1'b0);
        check("noack_to_a71", TIMEOUT, 1'b0);
        step();
        check("noack_high_a72", RST_N_OUT, 1'b1);
        check("noack_to_a72", TIMEOUT, 1'b1);
        check("noack_busy_a72", BUSY, 1'b1);
        step();
        check("noack_idle_a73", BUSY, 1'b0);
        check("noack_to_sticky", TIMEOUT, 1'b1);
        ack_mode = 0;
        step(6);
        pulse_req();
        check("noack_to_cleared", TIMEOUT, 1'b0);
        check("noack_new_low", RST_N_OUT, 1'b0);
        wait_idle("noack_recover_idle", 40);
        check("noack_recover_to", TIMEOUT, 1'b0);

        // ---- 4: acknowledge stuck high ----
        ack_mode = 2;
        step(4);
        check("spurious_ack_busy", BUSY, 1'b0);
        check("spurious_ack_rst_n", RST_N_OUT, 1'b1);
        pulse_req();
        step(8);
        check("stuck_high_a8", RST_N_OUT, 1'b1);
        step(63);
        check("stuck_busy_a71", BUSY, 1'b1);
        check("stuck_to_a71", TIMEOUT, 1'b0);
        step();
        check("stuck_idle_a72", BUSY, 1'b0);
        check("stuck_to_a72", TIMEOUT, 1'b1);
        check("stuck_rst_n_a72", RST_N_OUT, 1'b1);
        pulse_req();
        check("stuck_reaccept_busy", BUSY, 1'b1);
        check("stuck_reaccept_low", RST_N_OUT, 1'b0);
        check("stuck_reaccept_to", TIMEOUT, 1'b0);
        step(72);
        check("stuck_again_idle", BUSY, 1'b0);
        check("stuck_again_to", TIMEOUT, 1'b1);

        // ---- 6: asynchronous reset while in WAIT_REL with TIMEOUT set ----
        ack_mode = 1;
        step(4);
        pulse_req();
        step(72);
        check("arst_pre_rst_n", RST_N_OUT, 1'b1);
        check("arst_pre_to", TIMEOUT, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        check("arst_rst_n_async", RST_N_OUT, 1'b0);
        check("arst_to_async", TIMEOUT, 1'b0);
        check("arst_busy_async", BUSY, 1'b1);
        ack_mode = 0;
        step(2);
        RST = 1'b0;
        step(7);
        check("arst_restart_low_e7", RST_N_OUT, 1'b0);
        step();
        check("arst_restart_high_e8", RST_N_OUT, 1'b1);
        wait_idle("arst_restart_idle", 40);
        check("arst_restart_to", TIMEOUT, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
